// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// The controller drives the master side; the datapath/memory sees the slave side.
interface multicycle_controller_if #(
   parameter int unsigned OPW = 7
);
   logic [OPW-1:0] op;
   logic           zero;
   logic           mem_ready;
   logic           pc_write;
   logic           adr_src;
   logic           mem_write;
   logic           ir_write;
   logic [1:0]     result_src;
   logic [1:0]     alu_src_a;
   logic [1:0]     alu_src_b;
   logic           reg_write;
   logic [1:0]     alu_op;
   logic           retire;
   logic           illegal;
   logic [3:0]     state;

   modport master (
      input  op, zero, mem_ready,
      output pc_write, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, reg_write, alu_op, retire, illegal, state
   );

   modport slave (
      output op, zero, mem_ready,
      input  pc_write, adr_src, mem_write, ir_write, result_src,
             alu_src_a, alu_src_b, reg_write, alu_op, retire, illegal, state
   );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences ALU, memory port,
// register file and PC/IR enables one step per clock, stalling on mem_ready.
module multicycle_controller #(
   parameter int unsigned OPW = 7
) (
   input logic                     clk,
   input logic                     rst_n,
   multicycle_controller_if.master bus
);
   localparam logic [OPW-1:0] OP_LW   = OPW'(7'b0000011);
   localparam logic [OPW-1:0] OP_SW   = OPW'(7'b0100011);
   localparam logic [OPW-1:0] OP_R    = OPW'(7'b0110011);
   localparam logic [OPW-1:0] OP_I    = OPW'(7'b0010011);
   localparam logic [OPW-1:0] OP_BEQ  = OPW'(7'b1100011);
   localparam logic [OPW-1:0] OP_JAL  = OPW'(7'b1101111);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      ALUWB    = 4'd7,
      EXECI    = 4'd8,
      JAL      = 4'd9,
      BEQ      = 4'd10
   } state_e;

   state_e     state_q, state_d;
   logic       pc_update_c, branch_c;
   logic       pc_write_c, adr_src_c, mem_write_c, ir_write_c;
   logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
   logic       reg_write_c, retire_c, illegal_c;

   // State register; reset aborts any instruction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= FETCH;
      else        state_q <= state_d;
   end

   // Next-state and control decode; outputs follow state, gated by mem_ready/zero where noted.
   always_comb begin
      state_d      = state_q;
      pc_update_c  = 1'b0;
      branch_c     = 1'b0;
      adr_src_c    = 1'b0;
      mem_write_c  = 1'b0;
      ir_write_c   = 1'b0;
      result_src_c = 2'b00;
      alu_src_a_c  = 2'b00;
      alu_src_b_c  = 2'b00;
      reg_write_c  = 1'b0;
      alu_op_c     = 2'b00;
      retire_c     = 1'b0;
      illegal_c    = 1'b0;

      case (state_q)
         FETCH: begin
            alu_src_b_c  = 2'b10;
            result_src_c = 2'b10;
            ir_write_c   = bus.mem_ready;
            pc_update_c  = bus.mem_ready;
            if (bus.mem_ready) state_d = DECODE;
         end
         DECODE: begin
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b01;
            case (bus.op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECR;
               OP_I:         state_d = EXECI;
               OP_BEQ:       state_d = BEQ;
               OP_JAL:       state_d = JAL;
               default: begin
                  state_d   = FETCH;
                  illegal_c = 1'b1;
               end
            endcase
         end
         MEMADR: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            state_d     = (bus.op == OP_LW) ? MEMREAD : MEMWRITE;
         end
         MEMREAD: begin
            adr_src_c = 1'b1;
            if (bus.mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            result_src_c = 2'b01;
            reg_write_c  = 1'b1;
            retire_c     = 1'b1;
            state_d      = FETCH;
         end
         MEMWRITE: begin
            // Strobe and address held for the whole wait, retire only on acceptance.
            adr_src_c   = 1'b1;
            mem_write_c = 1'b1;
            retire_c    = bus.mem_ready;
            if (bus.mem_ready) state_d = FETCH;
         end
         EXECR: begin
            alu_src_a_c = 2'b10;
            alu_op_c    = 2'b10;
            state_d     = ALUWB;
         end
         EXECI: begin
            alu_src_a_c = 2'b10;
            alu_src_b_c = 2'b01;
            alu_op_c    = 2'b10;
            state_d     = ALUWB;
         end
         ALUWB: begin
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
            state_d     = FETCH;
         end
         BEQ: begin
            alu_src_a_c = 2'b10;
            alu_op_c    = 2'b01;
            branch_c    = 1'b1;
            retire_c    = 1'b1;
            state_d     = FETCH;
         end
         JAL: begin
            // Jump target was computed in DECODE; rd write and retire happen in ALUWB.
            alu_src_a_c = 2'b01;
            alu_src_b_c = 2'b10;
            pc_update_c = 1'b1;
            state_d     = ALUWB;
         end
         default: state_d = FETCH;
      endcase

      pc_write_c = pc_update_c | (branch_c & bus.zero);
   end

   assign bus.pc_write   = pc_write_c;
   assign bus.adr_src    = adr_src_c;
   assign bus.mem_write  = mem_write_c;
   assign bus.ir_write   = ir_write_c;
   assign bus.result_src = result_src_c;
   assign bus.alu_src_a  = alu_src_a_c;
   assign bus.alu_src_b  = alu_src_b_c;
   assign bus.reg_write  = reg_write_c;
   assign bus.alu_op     = alu_op_c;
   assign bus.retire     = retire_c;
   assign bus.illegal    = illegal_c;
   assign bus.state      = 4'(state_q);
endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected control
// vectors are queued as stimulus is driven and compared as the DUT responds.
module tb_multicycle_controller;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       adr;
      logic       mw;
      logic       irw;
      logic [1:0] res;
      logic [1:0] a;
      logic [1:0] b;
      logic       rw;
      logic [1:0] aop;
      logic       ret;
      logic       ill;
   } obs_t;

   logic clk;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];

   multicycle_controller_if #(.OPW(7)) bus ();

   multicycle_controller #(.OPW(7)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected control vector for a given state, straight from the state table.
   function automatic obs_t exp_for(int st, logic mr, logic z, logic [6:0] o);
      obs_t e;
      e    = '0;
      e.st = 4'(st);
      case (st)
         0:  begin e.b = 2'b10; e.res = 2'b10; e.irw = mr; e.pcw = mr; end
         1:  begin
                e.a = 2'b01; e.b = 2'b01;
                e.ill = !(o == OP_LW || o == OP_SW || o == OP_R || o == OP_I ||
                          o == OP_BEQ || o == OP_JAL);
             end
         2:  begin e.a = 2'b10; e.b = 2'b01; end
         3:  e.adr = 1'b1;
         4:  begin e.res = 2'b01; e.rw = 1'b1; e.ret = 1'b1; end
         5:  begin e.adr = 1'b1; e.mw = 1'b1; e.ret = mr; end
         6:  begin e.a = 2'b10; e.b = 2'b00; e.aop = 2'b10; end
         7:  begin e.rw = 1'b1; e.ret = 1'b1; end
         8:  begin e.a = 2'b10; e.b = 2'b01; e.aop = 2'b10; end
         9:  begin e.a = 2'b01; e.b = 2'b10; e.pcw = 1'b1; end
         10: begin e.a = 2'b10; e.aop = 2'b01; e.pcw = z; e.ret = 1'b1; end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic obs_t sample();
      obs_t s;
      s.st  = bus.state;      s.pcw = bus.pc_write;   s.adr = bus.adr_src;
      s.mw  = bus.mem_write;  s.irw = bus.ir_write;   s.res = bus.result_src;
      s.a   = bus.alu_src_a;  s.b   = bus.alu_src_b;  s.rw  = bus.reg_write;
      s.aop = bus.alu_op;     s.ret = bus.retire;     s.ill = bus.illegal;
      return s;
   endfunction

   task automatic test_reset();
      int   st [5];
      logic mr [5];
      obs_t got, want;
      st = '{0, 1, 6, 7, 0};
      mr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      rst_n = 1'b0; bus.mem_ready = 1'b0; bus.zero = 1'b0; bus.op = OP_R;
      @(negedge clk);
      exp_q.push_back(exp_for(0, 1'b0, 1'b0, OP_R));
      #2 got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset_idle got=%h want=%h", got, want); end
      bus.mem_ready = 1'b1;
      exp_q.push_back(exp_for(0, 1'b1, 1'b0, OP_R));
      #1 got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset_mr got=%h want=%h", got, want); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.mem_ready = mr[i];
         exp_q.push_back(exp_for(st[i], mr[i], 1'b0, OP_R));
         #2 got = sample(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL reset_release cyc%0d got=%h want=%h", i, got, want); end
      end
   endtask

   task automatic test_alu(input logic [6:0] op, input int exec_st);
      int   st [5];
      logic mr [5];
      obs_t got, want;
      st = '{0, 1, exec_st, 7, 0};
      mr = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      bus.op = op;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.mem_ready = mr[i];
         exp_q.push_back(exp_for(st[i], mr[i], bus.zero, op));
         #2 got = sample(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL alu op=%b cyc%0d got=%h want=%h", op, i, got, want); end
      end
   endtask

   task automatic test_lw_wait();
      int   st [9];
      logic mr [9];
      obs_t got, want;
      st = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
      mr = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      bus.op = OP_LW;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.mem_ready = mr[i];
         exp_q.push_back(exp_for(st[i], mr[i], bus.zero, OP_LW));
         #2 got = sample(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL lw_wait cyc%0d got=%h want=%h", i, got, want); end
      end
   endtask

   task automatic test_sw();
      int   st [7];
      logic mr [7];
      obs_t got, want;
      st = '{0, 0, 1, 2, 5, 5, 0};
      mr = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      bus.op = OP_SW;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         bus.mem_ready = mr[i];
         exp_q.push_back(exp_for(st[i], mr[i], bus.zero, OP_SW));
         #2 got = sample(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL sw cyc%0d got=%h want=%h", i, got, want); end
      end
   endtask

   task automatic test_beq(input logic z);
      int   st [4];
      obs_t got, want;
      st = '{0, 1, 10, 0};
      bus.op = OP_BEQ; bus.zero = z;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.mem_ready = (i == 0) ? 1'b1 : ((i == 3) ? 1'b0 : 1'($urandom_range(0, 1)));
         exp_q.push_back(exp_for(st[i], bus.mem_ready, z, OP_BEQ));
         #2 got = sample(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL beq zero=%b cyc%0d got=%h want=%h", z, i, got, want); end
      end
   endtask

   task automatic test_jal();
      int   st [5];
      obs_t got, want;
      st = '{0, 1, 9, 7, 0};
      bus.op = OP_JAL;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.mem_ready = (i == 0) ? 1'b1 : 1'b0;
         exp_q.push_back(exp_for(st[i], bus.mem_ready, bus.zero, OP_JAL));
         #2 got = sample(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL jal cyc%0d got=%h want=%h", i, got, want); end
      end
   endtask

   task automatic test_illegal(input logic [6:0] op);
      int   st [3];
      obs_t got, want;
      st = '{0, 1, 0};
      bus.op = op;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         bus.mem_ready = (i == 0) ? 1'b1 : 1'b0;
         exp_q.push_back(exp_for(st[i], bus.mem_ready, bus.zero, op));
         #2 got = sample(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL illegal op=%b cyc%0d got=%h want=%h", op, i, got, want); end
      end
   endtask

   task automatic test_back_to_back();
      int         st [13];
      logic       mr [13];
      logic [6:0] op [13];
      obs_t       got, want;
      st = '{0, 1, 6, 7, 0, 1, 10, 0, 1, 2, 3, 4, 0};
      mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      op = '{OP_R, OP_R, OP_R, OP_R, OP_R, OP_BEQ, OP_BEQ, OP_BEQ,
             OP_LW, OP_LW, OP_LW, OP_LW, OP_LW};
      bus.zero = 1'b1;
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         bus.mem_ready = mr[i];
         bus.op        = op[i];
         exp_q.push_back(exp_for(st[i], mr[i], 1'b1, op[i]));
         #2 got = sample(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL back_to_back cyc%0d got=%h want=%h", i, got, want); end
      end
      bus.zero = 1'b0;
   endtask

   task automatic test_reset_mid_sw();
      int   st [6];
      logic mr [6];
      obs_t got, want;
      st = '{0, 1, 2, 5, 5, 5};
      mr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      bus.op = OP_SW;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         bus.mem_ready = mr[i];
         exp_q.push_back(exp_for(st[i], mr[i], bus.zero, OP_SW));
         #2 got = sample(); want = exp_q.pop_front(); checks++;
         if (got !== want) begin errors++; $display("FAIL sw_wait cyc%0d got=%h want=%h", i, got, want); end
      end
      #1 rst_n = 1'b0;
      exp_q.push_back(exp_for(0, 1'b0, bus.zero, OP_SW));
      #1 got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset_abort got=%h want=%h", got, want); end
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      exp_q.push_back(exp_for(0, 1'b0, bus.zero, OP_SW));
      #2 got = sample(); want = exp_q.pop_front(); checks++;
      if (got !== want) begin errors++; $display("FAIL reset_abort_idle got=%h want=%h", got, want); end
   endtask

   initial begin
      test_reset();
      test_alu(OP_R, 6);
      test_alu(OP_I, 8);
      test_lw_wait();
      test_sw();
      test_beq(1'b1);
      test_beq(1'b0);
      test_jal();
      test_illegal(7'b0000000);
      test_illegal(7'b1110011);
      test_back_to_back();
      test_reset_mid_sw();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d want=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time=%0t limit=100000", $time);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multicycle RV32I core (lw, sw, R-type, I-type ALU, beq, jal). It reads the instruction-register opcode and the ALU zero flag, and sequences the shared ALU, unified memory port, register file and PC/IR enables one step per clock. It produces the `alu_op` code consumed by the ALU decoder. Memory accesses stall on a `mem_ready` handshake.

## Interface
Parameters:
- `OPW`, default 7: opcode width.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in OPW: opcode from the instruction register. Stable except in the cycle after an `ir_write`.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pc_write` out 1: PC load enable.
- `adr_src` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_write` out 1: memory write strobe.
- `ir_write` out 1: IR and OldPC load enable.
- `result_src` out 2: result mux select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = rs1.
- `alu_src_b` out 2: ALU B select. 00 = rs2, 01 = imm, 10 = const 4.
- `reg_write` out 1: register file write enable.
- `alu_op` out 2: to ALU decoder. 00 = add, 01 = sub/compare, 10 = funct-decoded.
- `retire` out 1: one-cycle pulse when an instruction completes.
- `illegal` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state, for debug.

## Operation
- State register is 4 bits. Encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11–15 transition to FETCH.
- Outputs are Moore, decoded from state, except where a term below names `mem_ready` or `zero`. Any output not listed for a state is 0.
- `pc_write` = `pc_update` | (`branch` & `zero`). `pc_update` and `branch` are internal signals.
- FETCH:
  - a_src=00, b_src=10, alu_op=00, result_src=10.
  - `ir_write` = `mem_ready`; `pc_update` = `mem_ready`.
  - Goes to DECODE when `mem_ready`=1, otherwise stays in FETCH.
- DECODE:
  - a_src=01, b_src=01, alu_op=00 (branch target into ALUOut).
  - Next state by `op`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BEQ
    - 1101111 → JAL
    - anything else → FETCH with `illegal`=1.
- MEMADR: a=10, b=01, alu_op=00. Goes to MEMREAD if `op`=0000011, otherwise MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Goes to MEMWB when `mem_ready`, otherwise holds.
- MEMWB: result_src=01, reg_write=1, retire=1. Goes to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 (held until accepted). Goes to FETCH when `mem_ready`, with retire=`mem_ready`.
- EXECR: a=10, b=00, alu_op=10. Goes to ALUWB.
- EXECI: a=10, b=01, alu_op=10. Goes to ALUWB.
- ALUWB: result_src=00, reg_write=1, retire=1. Goes to FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1, retire=1. Goes to FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1, retire=1. Goes to ALUWB (writes rd = OldPC+4); `retire` fires in ALUWB, not in JAL.
- Correction to JAL: `retire`=0 in JAL. The single retire pulse for jal comes from ALUWB.

## Timing
- Reset: `rst_n`=0 forces FETCH immediately (asynchronous). While in reset all outputs equal the FETCH decode with `mem_ready` gating; `state`=0, `illegal`=0, `retire`=0. Release is synchronous to the next edge.
- Latency with `mem_ready` tied to 1:
  - R-type, I-type, sw, jal: 4 cycles.
  - beq: 3 cycles.
  - lw: 5 cycles.
  - Each memory-state wait cycle adds 1.
- `mem_ready` is only sampled in FETCH, MEMREAD and MEMWRITE; it is ignored elsewhere.
- `mem_write` and `adr_src` stay stable for the entire MEMWRITE wait.
- Reset asserted mid-instruction aborts it. No partial `reg_write` or `pc_write` occurs after reset asserts.
- `illegal` and `retire` are never high in the same cycle.

## Test plan
- Reset held, `mem_ready`=0 → state=0; all outputs 0 except a=00, b=10, result_src=10. Release, `mem_ready`=1 → `ir_write`=`pc_write`=1, state goes 0→1.
- `op`=0110011, `mem_ready`=1 → states 0,1,6,7,0; alu_op=10 in EXECR; `reg_write` and `retire` only in ALUWB.
- `op`=0000011, `mem_ready` low for 3 cycles in MEMREAD → states 0,1,2,3,3,3,3,4,0; adr_src=1 throughout MEMREAD.
- `op`=1100011: `zero`=1 → `pc_write`=1 in BEQ; `zero`=0 → `pc_write`=0; both cases return to FETCH after 3 cycles.
- `op`=0000000 → `illegal` pulses in DECODE, next state FETCH, no `reg_write` or `mem_write`.
- `op`=0100011 with `mem_ready`=0 in MEMWRITE, then `rst_n` pulsed low → state=0 immediately and `mem_write`=0.
